// File: rtl/posit_op_arbiter.sv
// posit_op_arbiter: two-requester front end for a combinational posit unit.
// Grants one operation at a time, waits for the unit to settle, returns the result.
module posit_op_arbiter #(
    parameter int DATA_W     = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*DATA_W-1:0] req_op1,
    input  logic [2*DATA_W-1:0] req_op2,
    output logic [DATA_W-1:0] pu_in_1,
    output logic [DATA_W-1:0] pu_in_2,
    input  logic [DATA_W-1:0] pu_res,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [7:0]        ops_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Counter starts at SETTLE_CYC-1 so SETTLE lasts exactly SETTLE_CYC cycles.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [7:0]        ops_q, ops_d;
    logic              win_id;

    // Winner: lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        win_id = 1'b0;
        unique case (req_valid)
            2'b01:   win_id = 1'b0;
            2'b10:   win_id = 1'b1;
            2'b11:   win_id = ~last_q;
            default: win_id = 1'b0;
        endcase
    end

    // Next-state, grant and datapath capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        id_d      = id_q;
        data_d    = data_q;
        last_d    = last_q;
        ops_d     = ops_q;
        req_ready = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (|req_valid && !rst) begin
                    req_ready = win_id ? 2'b10 : 2'b01;
                    op1_d     = win_id ? req_op1[2*DATA_W-1:DATA_W]
                                       : req_op1[DATA_W-1:0];
                    op2_d     = win_id ? req_op2[2*DATA_W-1:DATA_W]
                                       : req_op2[DATA_W-1:0];
                    id_d      = win_id;
                    cnt_d     = CNT_LOAD;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d  = pu_res;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    last_d  = id_q;
                    ops_d   = ops_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op1_q   <= '0;
            op2_q   <= '0;
            id_q    <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b1;
            ops_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            id_q    <= id_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ops_q   <= ops_d;
        end
    end

    assign pu_in_1   = op1_q;
    assign pu_in_2   = op2_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign busy      = (state_q != IDLE);
    assign ops_done  = ops_q;

endmodule
